rv32_mem_stage: RTL and testbench
=================================

Name: rv32_mem_stage

Overview:
- Pipeline stage directly downstream of the execute-stage ALU.
- Takes the registered ALU result and rs2 value and performs load/store accesses on the data bus: byte-lane steering, write-mask generation, load sign/zero extension and misalignment detection.
- Registers the writeback value, rd and valid into the mem/writeback pipeline register.
- Generates the stall for upstream stages while a bus access is outstanding.

Parameters:
None.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_in  in  1  downstream stall; hold output register
flush_in  in  1  squash the instruction currently in this stage
valid_in  in  1  instruction from execute is valid
rd_in  in  5  destination register
rd_write_in  in  1  instruction writes rd
result_in  in  32  ALU result (address for loads/stores, value otherwise)
rs2_value_in  in  32  store data
mem_read_in  in  1  load instruction
mem_write_in  in  1  store instruction
mem_width_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_zero_extend_in  in  1  1 = LBU/LHU, 0 = LB/LH
data_address_out  out  32  word-aligned bus address: {result_in[31:2],2'b00}
data_read_out  out  1  bus read request
data_write_out  out  1  bus write request
data_write_mask_out  out  4  byte enables for writes
data_write_value_out  out  32  lane-replicated store data
data_read_value_in  in  32  bus read data, valid when data_ready_in
data_ready_in  in  1  bus completes access this cycle
stall_out  out  1  hold upstream stages
valid_out  out  1  registered: instruction valid in writeback
rd_out  out  5  registered destination
rd_write_out  out  1  registered write enable
rd_value_out  out  32  registered writeback value
misaligned_out  out  1  registered: access was misaligned (trap request)

Behaviour:
- Reset (sync): valid_out=0, rd_out=0, rd_write_out=0, rd_value_out=0, misaligned_out=0. Bus outputs are combinational and depend only on the current inputs, so they are 0 whenever valid_in=0.
- Alignment: half is misaligned when addr[0]=1; word when addr[1:0]!=0; byte is never misaligned.
- access = valid_in & (mem_read_in | mem_write_in) & aligned & !flush_in & !stall_in.
- data_read_out = access & mem_read_in; data_write_out = access & mem_write_in & !mem_read_in (read has priority if both are set).
- Write mask:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0] (addr[1:0] is 0 or 2)
  - word: 4'b1111
  - 0 on reads.
- Write value: byte replicated x4, half replicated x2, word unchanged.
- Load extraction:
  - byte: lane addr[1:0] of the read data.
  - half: lane addr[1] of the read data.
  - Then sign-extend from bit 7/15, or zero-extend if mem_zero_extend_in=1. Word passes through.
- Bus wait: stall_out = stall_in | (access & !data_ready_in). A stalled access is re-presented unchanged each cycle until data_ready_in; exactly one completed write per store.
- Register update each rising edge, highest priority first:
  1. reset
  2. stall_in: hold all registered outputs
  3. flush_in: valid_out=0, rd_write_out=0, misaligned_out=0
  4. access & !data_ready_in: insert bubble (valid_out=0, rd_write_out=0)
  5. otherwise: valid_out=valid_in; rd_out=rd_in; rd_value_out=load data if mem_read_in else result_in; rd_write_out=valid_in & rd_write_in & !misaligned; misaligned_out=valid_in & (mem_read_in|mem_write_in) & !aligned.
- Misaligned access: no bus request, no stall, rd not written, misaligned_out=1 for one stage occupancy.
- Latency: non-memory instruction 1 cycle; load/store 1 cycle + bus wait cycles.
- data_ready_in when no request is ignored.
- flush_in during a pending access: the request drops the same cycle and no write occurs.

Test Plan:
- ALU passthrough: valid_in=1, result_in=0x1234_5678, rd_in=5, rd_write_in=1, no mem -> next cycle valid_out=1, rd_out=5, rd_value_out=0x1234_5678, no bus request.
- LB sign-extend: result_in=0x103, width=00, zext=0, read data 0x80xx_xxxx, ready=1 -> data_address_out=0x100, rd_value_out=0xFFFF_FF80; with zext=1 -> 0x0000_0080.
- SH at 0x202, rs2=0xABCD_1234 -> data_write_out=1, mask=4'b1100, write value=0x1234_1234, address=0x200.
- Bus wait: LW with data_ready_in low for 3 cycles -> stall_out high 3 cycles, request held, valid_out=0 during the wait; on the 4th cycle (ready=1, read data 0xDEAD_BEEF) -> next cycle valid_out=1, rd_value_out=0xDEAD_BEEF.
- Misaligned SW at 0x301 -> no data_write_out, stall_out=0, misaligned_out=1, rd_write_out=0.
- stall_in held 2 cycles with a valid store -> no bus write, outputs held; reset asserted mid-wait -> all registered outputs 0 next cycle.

Source files
------------

// File: rtl/rv32_mem_stage.sv
// -----------------------------------------------------------------------------
// rv32_mem_stage
//
// Memory stage of a simple RV32 pipeline. It sits after the execute-stage ALU,
// turns loads and stores into data-bus requests, and registers the writeback
// value into the mem/writeback pipeline register.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   stall_in / flush_in     downstream stall (hold) / squash current instruction
//   valid_in, rd_in,        instruction from execute: valid, destination,
//   rd_write_in, result_in  rd write enable, ALU result (address or value)
//   rs2_value_in            store data
//   mem_read_in/_write_in   load / store (read wins if both are set)
//   mem_width_in            00 byte, 01 half, 10/11 word
//   mem_zero_extend_in      1 = LBU/LHU, 0 = LB/LH
//   data_*_out / data_*_in  data bus: word address, read/write request, byte
//                           mask, lane-replicated store data, read data, ready
//   stall_out               hold upstream while a bus access is outstanding
//   valid_out, rd_out, rd_write_out, rd_value_out, misaligned_out
//                           registered mem/writeback pipeline outputs
// -----------------------------------------------------------------------------
module rv32_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        misaligned_out
);

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  logic [1:0]  byte_offset;
  logic        mem_op;
  logic        aligned;
  logic        access;
  logic [3:0]  write_mask;
  logic [31:0] write_value;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;

  logic        valid_q,      valid_d;
  logic [4:0]  rd_q,         rd_d;
  logic        rd_write_q,   rd_write_d;
  logic [31:0] rd_value_q,   rd_value_d;
  logic        misaligned_q, misaligned_d;

  assign byte_offset = result_in[1:0];
  assign mem_op      = mem_read_in | mem_write_in;

  // Alignment, byte enables, store-lane replication and load extraction.
  // NOTE: every signal assigned here gets a value on every path (defaults
  // first, default case arms), so no latches are inferred.
  always_comb begin
    aligned     = (byte_offset == 2'b00);
    write_mask  = 4'b1111;
    write_value = rs2_value_in;
    case (mem_width_in)
      WIDTH_BYTE: begin
        aligned     = 1'b1;
        write_mask  = 4'b0001 << byte_offset;
        write_value = {4{rs2_value_in[7:0]}};
      end
      WIDTH_HALF: begin
        aligned     = ~byte_offset[0];
        write_mask  = 4'b0011 << byte_offset;
        write_value = {2{rs2_value_in[15:0]}};
      end
      default: ;
    endcase

    case (byte_offset)
      2'd1:    byte_lane = data_read_value_in[15:8];
      2'd2:    byte_lane = data_read_value_in[23:16];
      2'd3:    byte_lane = data_read_value_in[31:24];
      default: byte_lane = data_read_value_in[7:0];
    endcase
    half_lane = byte_offset[1] ? data_read_value_in[31:16] : data_read_value_in[15:0];

    case (mem_width_in)
      WIDTH_BYTE: load_value = {{24{~mem_zero_extend_in & byte_lane[7]}}, byte_lane};
      WIDTH_HALF: load_value = {{16{~mem_zero_extend_in & half_lane[15]}}, half_lane};
      default:    load_value = data_read_value_in;
    endcase
  end

  // A bus access is only issued for an aligned memory op that is neither
  // squashed nor held by the downstream stall.
  assign access = valid_in & mem_op & aligned & ~flush_in & ~stall_in;

  assign data_read_out        = access & mem_read_in;
  assign data_write_out       = access & mem_write_in & ~mem_read_in;
  assign data_address_out     = valid_in ? {result_in[31:2], 2'b00} : 32'd0;
  assign data_write_mask_out  = data_write_out ? write_mask : 4'b0000;
  assign data_write_value_out = valid_in ? write_value : 32'd0;

  // While the bus has not answered, the request stays on the bus (inputs are
  // held upstream by stall_out) and a bubble goes down the pipe.
  assign stall_out = stall_in | (access & ~data_ready_in);

  // Pipeline-register next state, highest priority first after reset.
  always_comb begin
    valid_d      = valid_q;
    rd_d         = rd_q;
    rd_write_d   = rd_write_q;
    rd_value_d   = rd_value_q;
    misaligned_d = misaligned_q;
    if (stall_in) begin
      // hold everything
    end else if (flush_in) begin
      valid_d      = 1'b0;
      rd_write_d   = 1'b0;
      misaligned_d = 1'b0;
    end else if (access & ~data_ready_in) begin
      valid_d    = 1'b0;
      rd_write_d = 1'b0;
    end else begin
      valid_d      = valid_in;
      rd_d         = rd_in;
      rd_value_d   = mem_read_in ? load_value : result_in;
      rd_write_d   = valid_in & rd_write_in & ~(mem_op & ~aligned);
      misaligned_d = valid_in & mem_op & ~aligned;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rd_q         <= 5'd0;
      rd_write_q   <= 1'b0;
      rd_value_q   <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      rd_write_q   <= rd_write_d;
      rd_value_q   <= rd_value_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign valid_out      = valid_q;
  assign rd_out         = rd_q;
  assign rd_write_out   = rd_write_q;
  assign rd_value_out   = rd_value_q;
  assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_rv32_mem_stage
//
// Self-checking bench for rv32_mem_stage: a directed vector table, hand-written
// multi-cycle sequences (bus wait, downstream stall, reset, flush of a pending
// access) and randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_rv32_mem_stage;

  typedef struct packed {
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] result;
    logic [31:0] rs2;
    logic        mread;
    logic        mwrite;
    logic [1:0]  width;
    logic        zext;
    logic [31:0] rdata;
    logic        ready;
  } in_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rreq;
    logic        wreq;
    logic [3:0]  mask;
    logic [31:0] wval;
    logic        stall;
    logic        valid;
    logic [4:0]  rd;
    logic        rdw;
    logic [31:0] val;
    logic        mis;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall_in, flush_in, valid_in, rd_write_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in, rs2_value_in, data_read_value_in;
  logic        mem_read_in, mem_write_in, mem_zero_extend_in, data_ready_in;
  logic [1:0]  mem_width_in;
  logic [31:0] data_address_out, data_write_value_out, rd_value_out;
  logic        data_read_out, data_write_out, stall_out;
  logic [3:0]  data_write_mask_out;
  logic        valid_out, rd_write_out, misaligned_out;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  rv32_mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .stall_in             (stall_in),
    .flush_in             (flush_in),
    .valid_in             (valid_in),
    .rd_in                (rd_in),
    .rd_write_in          (rd_write_in),
    .result_in            (result_in),
    .rs2_value_in         (rs2_value_in),
    .mem_read_in          (mem_read_in),
    .mem_write_in         (mem_write_in),
    .mem_width_in         (mem_width_in),
    .mem_zero_extend_in   (mem_zero_extend_in),
    .data_address_out     (data_address_out),
    .data_read_out        (data_read_out),
    .data_write_out       (data_write_out),
    .data_write_mask_out  (data_write_mask_out),
    .data_write_value_out (data_write_value_out),
    .data_read_value_in   (data_read_value_in),
    .data_ready_in        (data_ready_in),
    .stall_out            (stall_out),
    .valid_out            (valid_out),
    .rd_out               (rd_out),
    .rd_write_out         (rd_write_out),
    .rd_value_out         (rd_value_out),
    .misaligned_out       (misaligned_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model ---
  logic [31:0] m_addr, m_wval, m_load;
  logic [3:0]  m_mask;
  logic        m_aligned, m_access, m_rreq, m_wreq, m_stall;
  logic        m_valid, m_rdw, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus-side behaviour computed from access size and byte offset.
  task automatic model_comb(input in_t t);
    int unsigned size, off;
    logic [31:0] v, mask;
    size = (t.width == 2'b00) ? 1 : (t.width == 2'b01) ? 2 : 4;
    off  = int'(t.result[1:0]);
    m_aligned = ((off % size) == 0);
    m_access  = t.valid && (t.mread || t.mwrite) && m_aligned && !t.flush && !t.stall;
    m_rreq    = m_access && t.mread;
    m_wreq    = m_access && t.mwrite && !t.mread;
    m_addr    = t.valid ? t.result - off : 32'd0;
    if (size == 1)      mask = 32'd1 << off;
    else if (size == 2) mask = 32'd3 << off;
    else                mask = 32'd15;
    m_mask = m_wreq ? mask[3:0] : 4'd0;
    if (size == 1)      v = {24'd0, t.rs2[7:0]} * 32'h0101_0101;
    else if (size == 2) v = {16'd0, t.rs2[15:0]} * 32'h0001_0001;
    else                v = t.rs2;
    m_wval = t.valid ? v : 32'd0;
    if (size == 1) begin
      v = (t.rdata >> (8 * off)) & 32'hFF;
      if (!t.zext && v >= 128) v = v - 256;
    end else if (size == 2) begin
      v = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
      if (!t.zext && v >= 32768) v = v - 65536;
    end else begin
      v = t.rdata;
    end
    m_load  = v;
    m_stall = t.stall || (m_access && !t.ready);
  endtask

  // Pipeline register update at the clock edge (model_comb must be current).
  task automatic model_seq(input in_t t);
    logic mem;
    mem = t.mread || t.mwrite;
    if (t.reset) begin
      m_valid = 0; m_rd = 0; m_rdw = 0; m_val = 0; m_mis = 0;
    end else if (t.stall) begin
    end else if (t.flush) begin
      m_valid = 0; m_rdw = 0; m_mis = 0;
    end else if (m_access && !t.ready) begin
      m_valid = 0; m_rdw = 0;
    end else begin
      m_valid = t.valid;
      m_rd    = t.rd;
      m_val   = t.mread ? m_load : t.result;
      m_rdw   = t.valid && t.rdw && !(mem && !m_aligned);
      m_mis   = t.valid && mem && !m_aligned;
    end
  endtask

  task automatic apply(input in_t t);
    reset              = t.reset;
    stall_in           = t.stall;
    flush_in           = t.flush;
    valid_in           = t.valid;
    rd_in              = t.rd;
    rd_write_in        = t.rdw;
    result_in          = t.result;
    rs2_value_in       = t.rs2;
    mem_read_in        = t.mread;
    mem_write_in       = t.mwrite;
    mem_width_in       = t.width;
    mem_zero_extend_in = t.zext;
    data_read_value_in = t.rdata;
    data_ready_in      = t.ready;
  endtask

  // One clock: bus outputs checked before the edge, registers after it.
  task automatic run_cycle(input in_t t, input string tag);
    apply(t);
    #1;
    model_comb(t);
    check({tag, " address"}, data_address_out, m_addr);
    check({tag, " read"}, 32'(data_read_out), 32'(m_rreq));
    check({tag, " write"}, 32'(data_write_out), 32'(m_wreq));
    check({tag, " mask"}, 32'(data_write_mask_out), 32'(m_mask));
    check({tag, " wvalue"}, data_write_value_out, m_wval);
    check({tag, " stall_out"}, 32'(stall_out), 32'(m_stall));
    @(posedge clk);
    #1;
    model_seq(t);
    check({tag, " valid_out"}, 32'(valid_out), 32'(m_valid));
    check({tag, " rd_out"}, 32'(rd_out), 32'(m_rd));
    check({tag, " rd_write_out"}, 32'(rd_write_out), 32'(m_rdw));
    check({tag, " rd_value_out"}, rd_value_out, m_val);
    check({tag, " misaligned_out"}, 32'(misaligned_out), 32'(m_mis));
  endtask

  function automatic in_t mk_in(logic valid, logic [4:0] rd, logic rdw, logic [31:0] result,
                                logic [31:0] rs2, logic mread, logic mwrite, logic [1:0] width,
                                logic zext, logic [31:0] rdata, logic ready, logic flush);
    in_t t;
    t = '0;
    t.valid = valid; t.rd = rd; t.rdw = rdw; t.result = result; t.rs2 = rs2;
    t.mread = mread; t.mwrite = mwrite; t.width = width; t.zext = zext;
    t.rdata = rdata; t.ready = ready; t.flush = flush;
    return t;
  endfunction

  function automatic exp_t mk_exp(logic [31:0] addr, logic rreq, logic wreq, logic [3:0] mask,
                                  logic [31:0] wval, logic stall, logic valid, logic [4:0] rd,
                                  logic rdw, logic [31:0] val, logic mis);
    exp_t e;
    e.addr = addr; e.rreq = rreq; e.wreq = wreq; e.mask = mask; e.wval = wval;
    e.stall = stall; e.valid = valid; e.rd = rd; e.rdw = rdw; e.val = val; e.mis = mis;
    return e;
  endfunction

  vec_t vecs[8];

  initial begin
    in_t t;
    in_t s;

    // Directed vectors, applied back to back after reset.
    vecs[0].i = mk_in(1, 5, 1, 32'h1234_5678, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    vecs[0].e = mk_exp(32'h1234_5678, 0, 0, 4'b0000, 0, 0, 1, 5, 1, 32'h1234_5678, 0);
    vecs[1].i = mk_in(1, 6, 1, 32'h103, 0, 1, 0, 2'b00, 0, 32'h8011_2233, 1, 0);
    vecs[1].e = mk_exp(32'h100, 1, 0, 4'b0000, 0, 0, 1, 6, 1, 32'hFFFF_FF80, 0);
    vecs[2].i = mk_in(1, 6, 1, 32'h103, 0, 1, 0, 2'b00, 1, 32'h8011_2233, 1, 0);
    vecs[2].e = mk_exp(32'h100, 1, 0, 4'b0000, 0, 0, 1, 6, 1, 32'h0000_0080, 0);
    vecs[3].i = mk_in(1, 0, 0, 32'h202, 32'hABCD_1234, 0, 1, 2'b01, 0, 0, 1, 0);
    vecs[3].e = mk_exp(32'h200, 0, 1, 4'b1100, 32'h1234_1234, 0, 1, 0, 0, 32'h202, 0);
    vecs[4].i = mk_in(1, 7, 1, 32'h301, 32'h55, 0, 1, 2'b10, 0, 0, 0, 0);
    vecs[4].e = mk_exp(32'h300, 0, 0, 4'b0000, 32'h55, 0, 1, 7, 0, 32'h301, 1);
    vecs[5].i = mk_in(0, 0, 0, 0, 32'hFFFF, 0, 0, 2'b00, 0, 0, 0, 0);
    vecs[5].e = mk_exp(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].i = mk_in(1, 9, 1, 32'h400, 0, 1, 0, 2'b10, 0, 32'h1111, 1, 1);
    vecs[6].e = mk_exp(32'h400, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    vecs[7].i = mk_in(1, 10, 1, 32'h402, 0, 1, 0, 2'b01, 0, 32'h8001_7FFF, 1, 0);
    vecs[7].e = mk_exp(32'h400, 1, 0, 4'b0000, 0, 0, 1, 10, 1, 32'hFFFF_8001, 0);

    // Reset with junk on the inputs: registers must still clear.
    t = mk_in(1, 31, 1, 32'hFFFF_FFFF, 0, 0, 0, 2'b10, 0, 0, 1, 0);
    t.reset = 1'b1;
    run_cycle(t, "reset");
    check("reset valid_out const", 32'(valid_out), 0);
    check("reset rd_value_out const", rd_value_out, 0);

    for (int k = 0; k < 8; k++) begin
      apply(vecs[k].i);
      #1;
      check($sformatf("vec%0d address", k), data_address_out, vecs[k].e.addr);
      check($sformatf("vec%0d read", k), 32'(data_read_out), 32'(vecs[k].e.rreq));
      check($sformatf("vec%0d write", k), 32'(data_write_out), 32'(vecs[k].e.wreq));
      check($sformatf("vec%0d mask", k), 32'(data_write_mask_out), 32'(vecs[k].e.mask));
      check($sformatf("vec%0d wvalue", k), data_write_value_out, vecs[k].e.wval);
      check($sformatf("vec%0d stall_out", k), 32'(stall_out), 32'(vecs[k].e.stall));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d valid_out", k), 32'(valid_out), 32'(vecs[k].e.valid));
      check($sformatf("vec%0d rd_out", k), 32'(rd_out), 32'(vecs[k].e.rd));
      check($sformatf("vec%0d rd_write_out", k), 32'(rd_write_out), 32'(vecs[k].e.rdw));
      check($sformatf("vec%0d rd_value_out", k), rd_value_out, vecs[k].e.val);
      check($sformatf("vec%0d misaligned_out", k), 32'(misaligned_out), 32'(vecs[k].e.mis));
      model_comb(vecs[k].i);
      model_seq(vecs[k].i);
    end

    // Bus wait: LW held for three cycles without ready, then completes.
    t = mk_in(1, 11, 1, 32'h500, 0, 1, 0, 2'b10, 0, 32'h0BAD_F00D, 0, 0);
    for (int c = 0; c < 3; c++) begin
      run_cycle(t, "wait");
      check("wait stall_out high", 32'(stall_out), 1);
      check("wait read held", 32'(data_read_out), 1);
      check("wait address held", data_address_out, 32'h500);
      check("wait bubble", 32'(valid_out), 0);
    end
    t.ready = 1'b1;
    t.rdata = 32'hDEAD_BEEF;
    run_cycle(t, "wait done");
    check("wait done stall_out", 32'(stall_out), 0);
    check("wait done valid_out", 32'(valid_out), 1);
    check("wait done rd_value_out", rd_value_out, 32'hDEAD_BEEF);

    // Downstream stall with a store: no write, registers held; then reset mid-wait.
    s = mk_in(1, 12, 0, 32'h600, 32'hCAFE_F00D, 0, 1, 2'b10, 0, 0, 1, 0);
    s.stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      run_cycle(s, "hold");
      check("hold no write", 32'(data_write_out), 0);
      check("hold stall_out", 32'(stall_out), 1);
      check("hold rd_value_out", rd_value_out, 32'hDEAD_BEEF);
      check("hold valid_out", 32'(valid_out), 1);
    end
    s.stall = 1'b0;
    s.ready = 1'b0;
    run_cycle(s, "store wait");
    check("store wait write", 32'(data_write_out), 1);
    s.reset = 1'b1;
    run_cycle(s, "mid reset");
    check("mid reset valid_out", 32'(valid_out), 0);
    check("mid reset rd_value_out", rd_value_out, 0);
    check("mid reset rd_out", 32'(rd_out), 0);

    // Flush of a pending store drops the request in the same cycle.
    s.reset = 1'b0;
    run_cycle(s, "pend");
    s.flush = 1'b1;
    run_cycle(s, "flush pend");
    check("flush drops write", 32'(data_write_out), 0);
    check("flush no stall", 32'(stall_out), 0);

    // Randomized traffic; a stalled access is usually re-presented unchanged.
    t = '0;
    for (int n = 0; n < 600; n++) begin
      if (!(m_stall && !t.reset && $urandom_range(0, 3) != 0)) begin
        int op;
        t.stall  = ($urandom_range(0, 7) == 0);
        t.flush  = ($urandom_range(0, 9) == 0);
        t.valid  = ($urandom_range(0, 3) != 0);
        t.rd     = 5'($urandom);
        t.rdw    = 1'($urandom);
        t.result = $urandom;
        t.rs2    = $urandom;
        op       = $urandom_range(0, 3);
        t.mread  = (op == 1) || (op == 3 && $urandom_range(0, 3) == 0);
        t.mwrite = (op == 2) || (op == 3 && $urandom_range(0, 3) == 0);
        t.width  = 2'($urandom);
        t.zext   = 1'($urandom);
      end
      t.reset = ($urandom_range(0, 59) == 0);
      t.rdata = $urandom;
      t.ready = 1'($urandom);
      run_cycle(t, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
